lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
//
// PURPOSE
// - Receive-side counterpart of the random engine: consumes the serial bit stream an 8-bit
//   Fibonacci LFSR emits, self-synchronises to it, then predicts and checks every later bit.
// - Sits at the far end of a link or loopback driven by the random engine.
// - Reports lock status, a per-bit error pulse and saturating bit/error counters.
//
// PARAMETERS
// - CNT_W        16  width of bit_count and err_count
// - LOSS_THRESH  4   consecutive mismatches that force a resync (used only with the macro)
//
// PORTS
// - clk        in   1      clock
// - rst        in   1      synchronous active-high reset
// - tap        in   8      feedback tap mask; must equal the transmitter's; held static while locked
// - start      in   1      1-cycle pulse: clear counters, (re)enter SYNC
// - in_val     in   1      in is valid this cycle; one bit per asserted cycle
// - in         in   1      received serial bit
// - locked     out  1      1 while in CHECK
// - err        out  1      1-cycle pulse: previous checked bit mismatched
// - bit_count  out  CNT_W  bits checked since start (saturating)
// - err_count  out  CNT_W  mismatches since start (saturating)
//
// BEHAVIOUR
// - Stream model: generator state s; f = ^(s & tap); s_next = {s[6:0], f}; out bit = s[7].
// - Window w[7:0] holds the last 8 bits, oldest at MSB. Expected next bit exp = ^(w & tap).
// - Reset: state IDLE; w = 0; fill counter = 0; locked = 0; err = 0; both counters = 0.
// - IDLE: in_val ignored. start -> SYNC.
// - SYNC: each in_val beat: w <= {w[6:0], in}; fill++. On the 8th beat:
//     - w_new != 8'h00 -> CHECK, locked = 1 from the next cycle.
//     - w_new == 8'h00 (degenerate) -> stay in SYNC, fill = 0, refill.
//   No comparisons and no counter updates in SYNC.
// - CHECK: each in_val beat:
//     - compare in vs exp; bit_count++.
//     - On mismatch, err = 1 next cycle and err_count++.
//     - w <= {w[6:0], exp}: local generator free-runs and is never corrupted by received errors.
// - in_val = 0: no state, window or counter change; err = 0.
// - Latency: err, bit_count and err_count reflect a beat one cycle after that beat's edge.
// - Counters saturate at {CNT_W{1'b1}}; err still pulses at saturation.
// - start in any state, including mid-SYNC or CHECK:
//     - counters = 0; fill = 0; locked = 0; err = 0; -> SYNC.
//     - An in_val beat in the same cycle as start is discarded.
// - rst mid-operation: same as the reset values above; start is required to resume.
// - tap changes while locked are undefined; the bench must not do this.
//
// CONFIGURATION
// - Macro LFSR_CHECKER_RESYNC_EN.
// - Defined:
//     - A run counter counts consecutive CHECK mismatches; any match clears it.
//     - On reaching LOSS_THRESH: locked drops next cycle; -> SYNC with fill = 0.
//     - Counters are retained, not cleared.
//     - The err pulse for the threshold beat still fires.
// - Not defined: CHECK is left only via start or rst; lock is never lost on errors.
//
// TESTING
// - Clean lock: tap=8'hB8; stream from model LFSR seed 8'h01; start, 8 beats -> locked=1;
//   next 200 beats -> bit_count=200, err_count=0, err never high.
// - Single error: after lock, invert the 50th checked bit -> exactly one err pulse, one cycle
//   after that beat; err_count=1; later bits match (window uncorrupted).
// - Gapped valid: same stream with in_val toggling 1,0,0,1... -> identical counts to the
//   contiguous case; nothing changes on idle cycles.
// - Degenerate fill: 8 zero bits during SYNC -> stays unlocked; then 8 model bits -> locked=1.
// - Restart: start mid-CHECK with err_count=3 -> counters 0 and locked 0 next cycle; relock
//   after 8 beats. Reset mid-SYNC returns to IDLE with all outputs 0.
// - RESYNC_EN: LOSS_THRESH=4; after lock inject 4 consecutive flips -> 4 err pulses, locked=0
//   after the 4th; resume clean stream -> relock after 8 beats; err_count=4. Without the macro,
//   locked stays 1.

Source files
------------

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the serial stream of an 8-bit Fibonacci LFSR; latency 1 cycle (err/counters).
// No backpressure: one bit is consumed on every in_val cycle. Optional loss-of-lock resync: LFSR_CHECKER_RESYNC_EN.
module lfsr_checker #(
  parameter int CNT_W       = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tap,
  input  logic             start,
  input  logic             in_val,
  input  logic             in,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (LOSS_THRESH < 1) begin : g_thresh_chk
    $error("LOSS_THRESH must be at least 1");
  end

  state_t           state_q, state_d;
  logic [7:0]       win_q, win_d;
  logic [2:0]       fill_q, fill_d;
  logic             err_d;
  logic [CNT_W-1:0] bc_d, ec_d;
  logic             exp_bit;
  logic [7:0]       win_in;

`ifdef LFSR_CHECKER_RESYNC_EN
  localparam int RUN_W = $clog2(LOSS_THRESH + 1);
  logic [RUN_W-1:0] run_q, run_d;
`endif

  assign exp_bit = ^(win_q & tap);
  assign win_in  = {win_q[6:0], in};
  assign locked  = (state_q == CHECK);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    fill_d  = fill_q;
    err_d   = 1'b0;
    bc_d    = bit_count;
    ec_d    = err_count;
`ifdef LFSR_CHECKER_RESYNC_EN
    run_d   = run_q;
`endif
    if (start) begin
      state_d = SYNC;
      fill_d  = '0;
      bc_d    = '0;
      ec_d    = '0;
`ifdef LFSR_CHECKER_RESYNC_EN
      run_d   = '0;
`endif
    end else if (in_val) begin
      unique case (state_q)
        IDLE: ;
        SYNC: begin
          // fill wraps 7 -> 0 on the 8th beat, so an all-zero window simply refills
          win_d  = win_in;
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd7 && win_in != 8'h00) state_d = CHECK;
        end
        CHECK: begin
          // window follows the prediction, so received errors never poison it
          win_d = {win_q[6:0], exp_bit};
          if (bit_count != CNT_MAX) bc_d = bit_count + 1'b1;
          if (in != exp_bit) begin
            err_d = 1'b1;
            if (err_count != CNT_MAX) ec_d = err_count + 1'b1;
`ifdef LFSR_CHECKER_RESYNC_EN
            if (run_q == RUN_W'(LOSS_THRESH - 1)) begin
              state_d = SYNC;
              fill_d  = '0;
              run_d   = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            run_d = '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      fill_q    <= '0;
      err       <= 1'b0;
      bit_count <= '0;
      err_count <= '0;
`ifdef LFSR_CHECKER_RESYNC_EN
      run_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      fill_q    <= fill_d;
      err       <= err_d;
      bit_count <= bc_d;
      err_count <= ec_d;
`ifdef LFSR_CHECKER_RESYNC_EN
      run_q     <= run_d;
`endif
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: every driven cycle pushes the model's expected outputs,
// a monitor pops and compares after each clock edge.
module tb_lfsr_checker;

  localparam int CNT_W       = 8;
  localparam int LOSS_THRESH = 4;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_val = 1'b0;
  logic             in_bit = 1'b0;
  logic [7:0]       tap = 8'hB8;
  logic             locked, err;
  logic [CNT_W-1:0] bit_count, err_count;

  lfsr_checker #(.CNT_W(CNT_W), .LOSS_THRESH(LOSS_THRESH)) dut (
    .clk(clk), .rst(rst), .tap(tap), .start(start), .in_val(in_val), .in(in_bit),
    .locked(locked), .err(err), .bit_count(bit_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lk;
    logic e;
    int   bc;
    int   ec;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // reference model: mode 0 idle, 1 sync, 2 check; hist[0] is the newest bit
  int   m_mode = 0, m_fill = 0, m_bc = 0, m_ec = 0, m_run = 0;
  bit   m_err = 0;
  bit   m_hist [8];
  logic [7:0] g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit v, input bit b);
    int ones;
    bit pred, any;
    m_err = 0;
    if (r) begin
      m_mode = 0; m_fill = 0; m_bc = 0; m_ec = 0; m_run = 0;
      foreach (m_hist[i]) m_hist[i] = 0;
    end else if (s) begin
      m_mode = 1; m_fill = 0; m_bc = 0; m_ec = 0; m_run = 0;
    end else if (v && m_mode == 1) begin
      for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = b;
      m_fill++;
      if (m_fill == 8) begin
        m_fill = 0;
        any = 0;
        foreach (m_hist[i]) any |= m_hist[i];
        if (any) m_mode = 2;
      end
    end else if (v && m_mode == 2) begin
      ones = 0;
      for (int i = 0; i < 8; i++) if (tap[i] && m_hist[i]) ones++;
      pred = ones % 2;
      for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pred;
      m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
      if (b != pred) begin
        m_err = 1;
        m_ec = (m_ec < CMAX) ? m_ec + 1 : CMAX;
        m_run++;
`ifdef LFSR_CHECKER_RESYNC_EN
        if (m_run >= LOSS_THRESH) begin
          m_mode = 1; m_fill = 0; m_run = 0;
        end
`endif
      end else begin
        m_run = 0;
      end
    end
    sbq.push_back('{lk: (m_mode == 2), e: m_err, bc: m_bc, ec: m_ec});
  endtask

  task automatic tick(input bit r, input bit s, input bit v, input bit b);
    @(negedge clk);
    rst = r; start = s; in_val = v; in_bit = b;
    model_step(r, s, v, b);
  endtask

  task automatic next_bit(output bit b);
    b = g[7];
    g = {g[6:0], 1'($countones(g & tap) % 2)};
  endtask

  task automatic send(input int n, input int gap, input int ff, input int ft,
                      input bit alt, input bit rnd);
    for (int i = 0; i < n; i++) begin
      bit b, fl;
      int gn;
      next_bit(b);
      fl = (i >= ff && i <= ft) || (alt && (i % 2 == 1));
      if (rnd) fl = ($urandom_range(0, 15) == 0);
      tick(0, 0, 1, b ^ fl);
      gn = rnd ? int'($urandom_range(0, 2)) : gap;
      repeat (gn) tick(0, 0, 0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic restart_lock();
    tick(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    g = 8'h01;
    send(8, 0, 0, -1, 0, 0);
  endtask

  task automatic probe(input string name, input bit lk, input bit e, input int bc, input int ec);
    @(posedge clk);
    #2;
    check({name, ".locked"}, locked, lk);
    check({name, ".err"}, err, e);
    check({name, ".bit_count"}, bit_count, bc);
    check({name, ".err_count"}, err_count, ec);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        check("sb.locked", locked, x.lk);
        check("sb.err", err, x.e);
        check("sb.bit_count", bit_count, x.bc);
        check("sb.err_count", err_count, x.ec);
      end
    end
  end

  initial begin : stim
    repeat (3) tick(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    probe("reset", 0, 0, 0, 0);
    repeat (5) tick(0, 0, 1, 1'($urandom_range(0, 1)));
    probe("idle", 0, 0, 0, 0);

    restart_lock();
    probe("lock", 1, 0, 0, 0);
    send(200, 0, 0, -1, 0, 0);
    probe("clean", 1, 0, 200, 0);

    restart_lock();
    send(100, 0, 49, 49, 0, 0);
    probe("single_err", 1, 0, 100, 1);

    restart_lock();
    send(200, 2, 0, -1, 0, 0);
    probe("gapped", 1, 0, 200, 0);

    tick(0, 1, 0, 0);
    repeat (8) tick(0, 0, 1, 0);
    probe("degenerate", 0, 0, 0, 0);
    g = 8'h01;
    send(8, 0, 0, -1, 0, 0);
    probe("degen_relock", 1, 0, 0, 0);
    send(20, 1, 0, -1, 0, 0);

    restart_lock();
    repeat (3) send(10, 0, 5, 5, 0, 0);
    probe("pre_restart", 1, 0, 30, 3);
    tick(0, 1, 1, 1);
    probe("restart", 0, 0, 0, 0);
    g = 8'h01;
    send(8, 0, 0, -1, 0, 0);
    probe("relock", 1, 0, 0, 0);
    tick(0, 1, 0, 0);
    send(4, 0, 0, -1, 0, 0);
    repeat (2) tick(1, 0, 1, 1);
    probe("rst_mid_sync", 0, 0, 0, 0);
    repeat (3) tick(0, 0, 1, 1'($urandom_range(0, 1)));
    probe("rst_needs_start", 0, 0, 0, 0);

    restart_lock();
    send(10, 0, 0, -1, 0, 0);
    send(4, 0, 0, 3, 0, 0);
`ifdef LFSR_CHECKER_RESYNC_EN
    probe("loss", 0, 1, 14, 4);
    send(28, 0, 0, -1, 0, 0);
    probe("resync", 1, 0, 34, 4);
`else
    probe("loss", 1, 1, 14, 4);
    send(28, 0, 0, -1, 0, 0);
    probe("resync", 1, 0, 42, 4);
`endif

    restart_lock();
    send(600, 0, 0, -1, 1, 0);
    probe("saturate", 1, 1, CMAX, CMAX);

    restart_lock();
    send(300, 0, 0, -1, 0, 1);
    repeat (4) tick(0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
